// File: rtl/video_pkg.sv
// Shared video stream types: frame FSM states and pattern codes.
// Imported by the generator and by any stream consumer or bench.
package video_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } state_e;

  typedef enum logic [1:0] {
    PAT_HRAMP   = 2'd0,
    PAT_VRAMP   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_EDGE    = 2'd3
  } pat_e;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/video_stream_gen_pattern_core.sv
// Pixel value generator: maps (x, y, sel) to a registered pixel.
// Output is forced to zero whenever the pixel is not valid.
module pattern_core
  import video_pkg::*;
#(
  parameter int W  = 640,
  parameter int DW = 8,
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          de,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  pat_e          sel,
  output logic [DW-1:0] data
);

  logic [DW-1:0] pix;
  logic          cx;
  logic          cy;

  assign cx = ((int'(x) / 8) % 2) != 0;
  assign cy = ((int'(y) / 8) % 2) != 0;

  always_comb begin
    pix = '0;
    unique case (1'b1)
      (sel == PAT_HRAMP):   pix = DW'(x);
      (sel == PAT_VRAMP):   pix = DW'(y);
      (sel == PAT_CHECKER): pix = (cx ^ cy) ? '1 : '0;
      (sel == PAT_EDGE):    pix = (int'(x) >= W / 2) ? '1 : '0;
      default:              pix = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else begin
      data <= de ? pix : '0;
    end
  end

endmodule

// File: rtl/video_stream_gen.sv
// Frame timing generator: Vs/De/data stream with selectable test pattern.
// Outputs are registered from next-state values so they align with the FSM.
module video_stream_gen
  import video_pkg::*;
#(
  parameter int IMAGE_W  = 640,
  parameter int IMAGE_H  = 480,
  parameter int IMAGE_DW = 8,
  parameter int H_BLANK  = 160,
  parameter int VS_LINES = 2,
  parameter int V_BACK   = 33,
  parameter int V_FRONT  = 10
) (
  input  logic                InVideoClk,
  input  logic                InRst,
  input  logic                InEnable,
  input  logic [1:0]          InPatternSel,
  output logic                OutVideoClk,
  output logic                OutVideoVs,
  output logic                OutVideoDe,
  output logic [IMAGE_DW-1:0] OutVideoData,
  output logic                OutFrameDone
);

  localparam int L    = IMAGE_W + H_BLANK;
  localparam int HW   = $clog2(L);
  localparam int VMAX = max4(VS_LINES, V_BACK, IMAGE_H, V_FRONT);
  localparam int VW   = $clog2(VMAX + 1);

  state_e          state;
  state_e          nxt_state;
  logic [HW-1:0]   hcnt;
  logic [HW-1:0]   nxt_h;
  logic [VW-1:0]   vcnt;
  logic [VW-1:0]   nxt_v;
  pat_e            pat;
  pat_e            nxt_pat;
  int              nlines;
  logic            line_end;
  logic            last_line;
  logic            frame_end;
  logic            nxt_de;
  logic            nxt_done;

  assign OutVideoClk = InVideoClk;

  always_comb begin
    nlines = 1;
    unique case (state)
      VSYNC:   nlines = VS_LINES;
      VBACK:   nlines = V_BACK;
      ACTIVE:  nlines = IMAGE_H;
      VFRONT:  nlines = V_FRONT;
      default: nlines = 1;
    endcase
  end

  assign line_end  = hcnt == HW'(L - 1);
  assign last_line = int'(vcnt) == nlines - 1;

  always_comb begin
    nxt_state = state;
    nxt_h     = hcnt;
    nxt_v     = vcnt;
    nxt_pat   = pat;
    frame_end = 1'b0;
    if (state == IDLE) begin
      nxt_h = '0;
      nxt_v = '0;
      if (InEnable) begin
        nxt_state = VSYNC;
        nxt_pat   = pat_e'(InPatternSel);
      end
    end else if (!line_end) begin
      nxt_h = hcnt + 1'b1;
    end else begin
      nxt_h = '0;
      if (!last_line) begin
        nxt_v = vcnt + 1'b1;
      end else begin
        nxt_v = '0;
        unique case (state)
          VSYNC:   nxt_state = (V_BACK > 0) ? VBACK : ACTIVE;
          VBACK:   nxt_state = ACTIVE;
          ACTIVE: begin
            if (V_FRONT > 0) nxt_state = VFRONT;
            else frame_end = 1'b1;
          end
          VFRONT:  frame_end = 1'b1;
          default: nxt_state = IDLE;
        endcase
        // Back-to-back frames re-latch the pattern at the new Vs.
        if (frame_end) begin
          if (InEnable) begin
            nxt_state = VSYNC;
            nxt_pat   = pat_e'(InPatternSel);
          end else begin
            nxt_state = IDLE;
          end
        end
      end
    end
  end

  assign nxt_de = (nxt_state == ACTIVE) && (int'(nxt_h) < IMAGE_W);

  always_comb begin
    if (V_FRONT > 0) begin
      nxt_done = (nxt_state == VFRONT)
              && (nxt_h == HW'(L - 1))
              && (int'(nxt_v) == V_FRONT - 1);
    end else begin
      nxt_done = (nxt_state == ACTIVE)
              && (nxt_h == HW'(L - 1))
              && (int'(nxt_v) == IMAGE_H - 1);
    end
  end

  always_ff @(posedge InVideoClk) begin
    if (InRst) begin
      state        <= IDLE;
      hcnt         <= '0;
      vcnt         <= '0;
      pat          <= PAT_HRAMP;
      OutVideoVs   <= 1'b0;
      OutVideoDe   <= 1'b0;
      OutFrameDone <= 1'b0;
    end else begin
      state        <= nxt_state;
      hcnt         <= nxt_h;
      vcnt         <= nxt_v;
      pat          <= nxt_pat;
      OutVideoVs   <= nxt_state == VSYNC;
      OutVideoDe   <= nxt_de;
      OutFrameDone <= nxt_done;
    end
  end

  pattern_core #(
    .W  (IMAGE_W),
    .DW (IMAGE_DW),
    .XW (HW),
    .YW (VW)
  ) u_pattern (
    .clk  (InVideoClk),
    .rst  (InRst),
    .de   (nxt_de),
    .x    (nxt_h),
    .y    (nxt_v),
    .sel  (nxt_pat),
    .data (OutVideoData)
  );

endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen: directed table, corner sequences and
// randomized enable/pattern/reset against a frame-offset reference model.
module tb_video_stream_gen;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int HB = 4;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int L  = W + HB;
  localparam int F  = (VS + VB + H + VF) * L;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       vclk, vs, de, done;
  logic [7:0] data;

  logic       rst2 = 1'b1;
  logic       en2  = 1'b0;
  logic [1:0] sel2 = 2'd0;
  logic       vclk2, vs2, de2, done2;
  logic [7:0] data2;

  video_stream_gen #(
    .IMAGE_W(W), .IMAGE_H(H), .IMAGE_DW(8), .H_BLANK(HB),
    .VS_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .InVideoClk   (clk),
    .InRst        (rst),
    .InEnable     (en),
    .InPatternSel (sel),
    .OutVideoClk  (vclk),
    .OutVideoVs   (vs),
    .OutVideoDe   (de),
    .OutVideoData (data),
    .OutFrameDone (done)
  );

  video_stream_gen #(
    .IMAGE_W(16), .IMAGE_H(16), .IMAGE_DW(8), .H_BLANK(4),
    .VS_LINES(1), .V_BACK(1), .V_FRONT(1)
  ) dut2 (
    .InVideoClk   (clk),
    .InRst        (rst2),
    .InEnable     (en2),
    .InPatternSel (sel2),
    .OutVideoClk  (vclk2),
    .OutVideoVs   (vs2),
    .OutVideoDe   (de2),
    .OutVideoData (data2),
    .OutFrameDone (done2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit m_run = 1'b0;
  int m_o   = 0;
  int m_pat = 0;

  typedef struct {
    int t;
    int vs;
    int de;
    int data;
    int done;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_run = 1'b0;
      m_o   = 0;
      m_pat = 0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_o   = 0;
        m_pat = int'(sel);
      end
    end else if (m_o == F - 1) begin
      if (en) begin
        m_o   = 0;
        m_pat = int'(sel);
      end else begin
        m_run = 1'b0;
      end
    end else begin
      m_o++;
    end
  endtask

  task automatic model_out(output int evs, output int ede,
                           output int edat, output int edone);
    int line, col, y;
    evs = 0; ede = 0; edat = 0; edone = 0;
    if (m_run) begin
      line  = m_o / L;
      col   = m_o % L;
      y     = line - VS - VB;
      evs   = (line < VS) ? 1 : 0;
      edone = (m_o == F - 1) ? 1 : 0;
      if (y >= 0 && y < H && col < W) begin
        ede = 1;
        case (m_pat)
          0: edat = col % 256;
          1: edat = y % 256;
          2: edat = (((col / 8) ^ (y / 8)) % 2 != 0) ? 255 : 0;
          default: edat = (col < W / 2) ? 0 : 255;
        endcase
      end
    end
  endtask

  task automatic tick();
    int evs, ede, edat, edone;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_out(evs, ede, edat, edone);
    chk("model_vs",   32'(vs),   32'(evs));
    chk("model_de",   32'(de),   32'(ede));
    chk("model_data", 32'(data), 32'(edat));
    chk("model_done", 32'(done), 32'(edone));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    tick();
    chk("rst_vs",   32'(vs),   0);
    chk("rst_de",   32'(de),   0);
    chk("rst_data", 32'(data), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
  endtask

  initial begin
    int x2, y2, n2, exp2;
    tbl[0]  = '{1,  1, 0, 0, 0};
    tbl[1]  = '{12, 1, 0, 0, 0};
    tbl[2]  = '{13, 0, 0, 0, 0};
    tbl[3]  = '{24, 0, 0, 0, 0};
    tbl[4]  = '{25, 0, 1, 0, 0};
    tbl[5]  = '{26, 0, 1, 1, 0};
    tbl[6]  = '{32, 0, 1, 7, 0};
    tbl[7]  = '{33, 0, 0, 0, 0};
    tbl[8]  = '{37, 0, 1, 0, 0};
    tbl[9]  = '{72, 0, 0, 0, 0};
    tbl[10] = '{84, 0, 0, 0, 1};
    tbl[11] = '{85, 1, 0, 0, 0};

    @(negedge clk);
    do_reset();

    // Directed timing table, pattern 0.
    en  = 1'b1;
    sel = 2'd0;
    for (int t = 1; t <= 85; t++) begin
      tick();
      for (int i = 0; i < 12; i++) begin
        if (tbl[i].t == t) begin
          chk("tbl_vs",   32'(vs),   32'(tbl[i].vs));
          chk("tbl_de",   32'(de),   32'(tbl[i].de));
          chk("tbl_data", 32'(data), 32'(tbl[i].data));
          chk("tbl_done", 32'(done), 32'(tbl[i].done));
        end
      end
    end

    // Pattern 1; sel change and enable drop mid-frame.
    do_reset();
    en  = 1'b1;
    sel = 2'd1;
    for (int t = 1; t <= 84; t++) begin
      tick();
      if (t == 30) sel = 2'd3;
      if (t == 40) en = 1'b0;
      if (t == 61) chk("p1_line3", 32'(data), 3);
      if (t == 84) chk("drop_done", 32'(done), 1);
    end
    for (int t = 0; t < 20; t++) tick();
    chk("idle_vs", 32'(vs), 0);
    chk("idle_de", 32'(de), 0);

    // Pattern 3 vertical edge.
    do_reset();
    en  = 1'b1;
    sel = 2'd3;
    for (int t = 1; t <= 84; t++) begin
      tick();
      if (t >= 25 && t <= 32)
        chk("edge_px", 32'(data), (t - 25 < 4) ? 0 : 255);
    end
    en = 1'b0;
    for (int t = 0; t < 90; t++) tick();

    // Reset mid-frame, then fresh frame.
    do_reset();
    en  = 1'b1;
    sel = 2'd0;
    for (int t = 1; t <= 49; t++) tick();
    rst = 1'b1;
    tick();
    chk("abort_vs",   32'(vs),   0);
    chk("abort_de",   32'(de),   0);
    chk("abort_data", 32'(data), 0);
    chk("abort_done", 32'(done), 0);
    rst = 1'b0;
    tick();
    chk("restart_vs", 32'(vs), 1);
    for (int t = 0; t < F; t++) tick();

    // Randomized enable / pattern / reset.
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      else rst = 1'b0;
      if ((t / 250) % 3 == 2) en = ($urandom_range(0, 9) == 0);
      else en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
      tick();
    end

    // Checkerboard on a 16x16 instance.
    rst  = 1'b1;
    en   = 1'b0;
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    en2  = 1'b1;
    sel2 = 2'd2;
    x2 = 0;
    y2 = 0;
    n2 = 0;
    for (int t = 0; t < 380; t++) begin
      tick();
      if (t == 0) en2 = 1'b0;
      if (de2) begin
        exp2 = (((x2 / 8) ^ (y2 / 8)) % 2 != 0) ? 255 : 0;
        chk("checker_px", 32'(data2), 32'(exp2));
        n2++;
        x2++;
        if (x2 == 16) begin
          x2 = 0;
          y2++;
        end
      end
    end
    chk("checker_count", 32'(n2), 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
